fft_butterfly: RTL

- Radix-2 decimation-in-time butterfly for the waterfall FFT. It sits directly downstream of the twiddle ROM.
- Each accepted operand pair (a, b) comes with a twiddle index. The block drives that index onto the ROM address, receives the ROM's registered output one cycle later, and computes x = (a + b·w)/2 and y = (a − b·w)/2.
- Fully pipelined with valid/pass-through tags. The FFT sequencer feeds it, and the data RAM write-back consumes its output.

---
 rtl/fft_pkg.sv | 53 +++++
 rtl/fft_butterfly_if.sv | 42 ++++
 rtl/fft_butterfly_cmul_pipe.sv | 69 ++++++
 rtl/fft_butterfly.sv | 109 ++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types, widths and the output saturation helper.
// No timing of its own; used by the butterfly and the window stage.
// No flow control.
package fft_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int TW_ADDR_W = 9;
    localparam int TW_FRAC   = 7;
    localparam int TAG_W     = 10;
    localparam int TW_W      = 16;

    // Full-width b*w partial product, and the post-shift product kept for the add stage
    localparam int PROD_W = SAMPLE_W + TW_W;
    localparam int P_W    = SAMPLE_W + 2;
    // a +/- p needs one more bit than p
    localparam int SUM_W  = SAMPLE_W + 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [TW_W-1:0]     tw_t;
    typedef logic signed [P_W-1:0]      p_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    // Data that rides alongside the multiplier untouched
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        cplx_t            a;
    } side_t;

    typedef struct packed {
        logic    clip;
        sample_t val;
    } sat_t;

    // Clamp a SUM_W-bit signed value into a sample; the value fits only when all
    // bits from the sample sign bit upward agree.
    function automatic sat_t saturate(input logic signed [SUM_W-1:0] v);
        sat_t r;
        if ((v[SUM_W-1:SAMPLE_W-1] == '0) || (v[SUM_W-1:SAMPLE_W-1] == '1)) begin
            r.clip = 1'b0;
            r.val  = v[SAMPLE_W-1:0];
        end else begin
            r.clip = 1'b1;
            r.val  = v[SUM_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_butterfly_if.sv
// Butterfly operand/result bus, including the twiddle ROM address/data pair.
// Carries the one-pair-per-clock stream; no timing of its own.
// No backpressure: the consumer must take every valid beat.
interface fft_butterfly_if;
    import fft_pkg::*;

    logic                 in_valid;
    logic [TAG_W-1:0]     in_tag;
    logic [TW_ADDR_W-1:0] in_tw_idx;
    sample_t              a_re;
    sample_t              a_im;
    sample_t              b_re;
    sample_t              b_im;

    logic [TW_ADDR_W-1:0] tw_addr;
    tw_t                  tw_re;
    tw_t                  tw_im;

    logic                 out_valid;
    logic [TAG_W-1:0]     out_tag;
    sample_t              x_re;
    sample_t              x_im;
    sample_t              y_re;
    sample_t              y_im;
    logic                 sat;
    logic                 sat_clr;

    // Butterfly side
    modport slave (
        input  in_valid, in_tag, in_tw_idx, a_re, a_im, b_re, b_im,
        input  tw_re, tw_im, sat_clr,
        output tw_addr, out_valid, out_tag, x_re, x_im, y_re, y_im, sat
    );

    // Sequencer / ROM / write-back side
    modport master (
        output in_valid, in_tag, in_tw_idx, a_re, a_im, b_re, b_im,
        output tw_re, tw_im, sat_clr,
        input  tw_addr, out_valid, out_tag, x_re, x_im, y_re, y_im, sat
    );

endinterface

// File: rtl/fft_butterfly_cmul_pipe.sv
// Two-stage complex multiply p = (b*w) >>> TW_FRAC with side data and valid carried along.
// Latency 2 clk, one pair per clock.
// No backpressure.
module fft_butterfly_cmul_pipe
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    input  cplx_t in_b,
    input  tw_t   tw_re,
    input  tw_t   tw_im,
    input  side_t in_side,
    output logic  out_valid,
    output p_t    out_p_re,
    output p_t    out_p_im,
    output side_t out_side
);

    logic signed [PROD_W-1:0] prod_rr;
    logic signed [PROD_W-1:0] prod_ii;
    logic signed [PROD_W-1:0] prod_ri;
    logic signed [PROD_W-1:0] prod_ir;
    logic                     prod_valid;
    side_t                    prod_side;
    logic signed [PROD_W:0]   sum_re;
    logic signed [PROD_W:0]   sum_im;

    // First stage: the four full-width partial products; tw is the ROM word for this pair
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_rr    <= '0;
            prod_ii    <= '0;
            prod_ri    <= '0;
            prod_ir    <= '0;
            prod_valid <= 1'b0;
            prod_side  <= '0;
        end else begin
            prod_rr    <= PROD_W'($signed(in_b.re)) * PROD_W'(tw_re);
            prod_ii    <= PROD_W'($signed(in_b.im)) * PROD_W'(tw_im);
            prod_ri    <= PROD_W'($signed(in_b.re)) * PROD_W'(tw_im);
            prod_ir    <= PROD_W'($signed(in_b.im)) * PROD_W'(tw_re);
            prod_valid <= in_valid;
            prod_side  <= in_side;
        end
    end

    // Combine partial products one bit wider so the difference/sum cannot wrap
    always_comb begin
        sum_re = (PROD_W+1)'(prod_rr) - (PROD_W+1)'(prod_ii);
        sum_im = (PROD_W+1)'(prod_ri) + (PROD_W+1)'(prod_ir);
    end

    // Second stage: drop the twiddle fraction (floor, no rounding) and keep P_W bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_p_re  <= '0;
            out_p_im  <= '0;
            out_valid <= 1'b0;
            out_side  <= '0;
        end else begin
            out_p_re  <= P_W'(sum_re >>> TW_FRAC);
            out_p_im  <= P_W'(sum_im >>> TW_FRAC);
            out_valid <= prod_valid;
            out_side  <= prod_side;
        end
    end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: x = (a + b*w)/2, y = (a - b*w)/2 with saturation and sticky sat flag.
// Latency 4 clk from in_valid to out_valid, one pair per clock.
// No backpressure; results hold their last value while out_valid is low.
module fft_butterfly
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fft_butterfly_if.slave bus
);

    logic               s1_valid;
    cplx_t              s1_b;
    side_t              s1_side;

    logic               s3_valid;
    p_t                 s3_p_re;
    p_t                 s3_p_im;
    side_t              s3_side;

    logic signed [SUM_W-1:0] sx_re;
    logic signed [SUM_W-1:0] sx_im;
    logic signed [SUM_W-1:0] sy_re;
    logic signed [SUM_W-1:0] sy_im;
    sat_t               xr_s;
    sat_t               xi_s;
    sat_t               yr_s;
    sat_t               yi_s;
    logic               any_clip;

    // The ROM registers the address itself, so its word lines up with stage 1
    assign bus.tw_addr = bus.in_tw_idx;

    // Input stage: capture the operand pair, tag and valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_b     <= '0;
            s1_side  <= '0;
        end else begin
            s1_valid     <= bus.in_valid;
            s1_b.re      <= bus.b_re;
            s1_b.im      <= bus.b_im;
            s1_side.tag  <= bus.in_tag;
            s1_side.a.re <= bus.a_re;
            s1_side.a.im <= bus.a_im;
        end
    end

    fft_butterfly_cmul_pipe u_cmul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_b      (s1_b),
        .tw_re     (bus.tw_re),
        .tw_im     (bus.tw_im),
        .in_side   (s1_side),
        .out_valid (s3_valid),
        .out_p_re  (s3_p_re),
        .out_p_im  (s3_p_im),
        .out_side  (s3_side)
    );

    // Add/subtract, halve (floor) and clamp each component
    always_comb begin
        sx_re    = SUM_W'($signed(s3_side.a.re)) + SUM_W'(s3_p_re);
        sx_im    = SUM_W'($signed(s3_side.a.im)) + SUM_W'(s3_p_im);
        sy_re    = SUM_W'($signed(s3_side.a.re)) - SUM_W'(s3_p_re);
        sy_im    = SUM_W'($signed(s3_side.a.im)) - SUM_W'(s3_p_im);
        xr_s     = saturate(sx_re >>> 1);
        xi_s     = saturate(sx_im >>> 1);
        yr_s     = saturate(sy_re >>> 1);
        yi_s     = saturate(sy_im >>> 1);
        any_clip = xr_s.clip | xi_s.clip | yr_s.clip | yi_s.clip;
    end

    // Output registers update only on a valid result so the write-back sees stable data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_tag   <= '0;
            bus.x_re      <= '0;
            bus.x_im      <= '0;
            bus.y_re      <= '0;
            bus.y_im      <= '0;
        end else begin
            bus.out_valid <= s3_valid;
            if (s3_valid) begin
                bus.out_tag <= s3_side.tag;
                bus.x_re    <= xr_s.val;
                bus.x_im    <= xi_s.val;
                bus.y_re    <= yr_s.val;
                bus.y_im    <= yi_s.val;
            end
        end
    end

    // Sticky saturation flag; a new clip beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sat <= 1'b0;
        end else if (s3_valid && any_clip) begin
            bus.sat <= 1'b1;
        end else if (bus.sat_clr) begin
            bus.sat <= 1'b0;
        end
    end

endmodule
